muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the single-cycle ALU in the execute stage. The stage hands it operands with a start pulse and holds the instruction in EX while `busy` is high. It returns the result with a one-cycle `done` pulse and a pass-through tag. Width and tag size are generic, so the same unit serves datapaths other than 32-bit.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width in bits; must be ≥ 4 and even.
- `TAG_W`, 5: width of the opaque tag (rd index) carried from request to result.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request valid; accepted only when `ready`=1 and `flush`=0.
- `op`  in  3: RISC-V M funct3.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  WIDTH: rs1 value.
- `b`  in  WIDTH: rs2 value.
- `tag_in`  in  TAG_W: tag captured on accept.
- `flush`  in  1: abort any in-flight operation.
- `ready`  out  1: unit idle; a request can be accepted this cycle.
- `busy`  out  1: operation in flight; equals !`ready`.
- `done`  out  1: single-cycle pulse; `result` and `tag_out` are valid.
- `result`  out  WIDTH: operation result; holds its value until the next `done`.
- `tag_out`  out  TAG_W: tag of the completed operation.

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE.
- S_IDLE:
  - `ready`=1.
  - On accept: latch `op`, operand magnitudes, sign flags and `tag_in`; clear the iteration counter.
  - If the request is a special case (see below), go to S_DONE; otherwise go to S_RUN.
- S_RUN:
  - One radix-2 step per cycle for exactly WIDTH cycles.
  - Counter width: $clog2(WIDTH)+1. Leave S_RUN when the counter reaches WIDTH-1, then go to S_DONE.
- S_DONE:
  - `done`=1; register `result` and `tag_out`.
  - Go to S_IDLE unconditionally. Back-to-back requests cannot overlap.
- Multiply (shift-add on magnitudes; 2·WIDTH-bit product):
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
  - Signedness: MULH treats both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. MULHU treats both as unsigned.
  - Negate the full 2·WIDTH product when the operand signs differ, before selecting the high or low word.
- Divide (restoring, on magnitudes):
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). This truncates toward zero.
  - DIVU and REMU use raw unsigned operands.
- Special cases are resolved at accept and take the S_IDLE→S_DONE fast path:
  - Divide by zero (b=0): DIV and DIVU return all-ones; REM and REMU return `a`.
  - Signed overflow (DIV/REM with a=most-negative and b=all-ones): DIV returns `a`; REM returns 0.
- `flush`:
  - From any state, the next state is S_IDLE; `done` is not asserted.
  - `result` and `tag_out` keep their prior values.
  - If `start` and `flush` are high in the same cycle, `flush` wins and the request is dropped.
- `start` while `busy`: ignored. The stage must hold the request until `ready`.
- Reset:
  - State is S_IDLE.
  - `ready`=1, `busy`=0, `done`=0.
  - `result`=0, `tag_out`=0; counter and datapath registers cleared.
- Reset during S_RUN: the operation is abandoned with no `done`. This is identical to `flush`.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Normal latency: accept at edge N; `done` is high during cycle N+WIDTH+1; `ready` is high again at N+WIDTH+2.
- Special-case latency: `done` is high during cycle N+1; `ready` is high at N+2.
- Throughput: one operation per WIDTH+2 cycles (per 2 cycles for special cases).
- The stage treats `busy` as a stall for EX and everything upstream. Writeback consumes `result` only when `done`=1.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), WIDTH=32 → `result`=0xFFFFFFEB, `done` exactly 33 cycles after accept, `tag_out`=`tag_in`.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, each with `done` 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Flush and reset:
  - `flush` at cycle 10 of S_RUN → no `done`, `ready`=1 next cycle, `result` unchanged.
  - `start` coincident with `flush` → not accepted.
  - `rst` mid-run → all outputs at reset values.
- `start` held high continuously with changing operands → only requests presented while `ready`=1 are accepted; one `done` per WIDTH+2 cycles; WIDTH=8 build repeats the MUL/DIV vectors truncated to 8 bits.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The stage drives the master side; the unit takes the slave side.
interface muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output start, op, a, b, tag_in, flush,
    input  ready, busy, done, result, tag_out
  );

  modport slave (
    input  start, op, a, b, tag_in, flush,
    output ready, busy, done, result, tag_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one radix-2 step per cycle, signs applied when the result is formed.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             sa, sb;
  logic [WIDTH-1:0] hi, lo, dvsr;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] result_q;
  logic [TAG_W-1:0] tag_out_q;

  // Request decode
  logic             accept, is_div, sa_in, sb_in, div_zero, ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    accept   = (state == S_IDLE) && bus.start && !bus.flush;
    is_div   = bus.op[2];
    // Signed operands: DIV/REM both; MUL/MULH both; MULHSU only a; MULHU neither.
    sa_in    = bus.a[WIDTH-1] & (is_div ? !bus.op[0] : (bus.op[1:0] != 2'b11));
    sb_in    = bus.b[WIDTH-1] & (is_div ? !bus.op[0] : !bus.op[1]);
    a_mag    = sa_in ? -bus.a : bus.a;
    b_mag    = sb_in ? -bus.b : bus.b;
    div_zero = is_div && (bus.b == '0);
    ovf      = is_div && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    special  = div_zero || ovf;
    if (div_zero)
      spec_res = bus.op[1] ? bus.a : '1;
    else
      spec_res = bus.op[1] ? '0 : bus.a;
  end

  // One iteration step plus the signed result formed from the stepped values
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   hi_n, lo_n, quot, rem, fin_res;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               diff_unused;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvsr} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    diff_unused = diff[WIDTH];
    if (op_q[2]) begin
      if (!diff[WIDTH+1]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
    prod   = {hi_n, lo_n};
    prod_s = (sa ^ sb) ? -prod : prod;
    quot   = (sa ^ sb) ? -lo_n : lo_n;
    rem    = sa ? -hi_n : hi_n;
    if (op_q[2])
      fin_res = op_q[1] ? rem : quot;
    else if (op_q[1:0] == 2'b00)
      fin_res = prod_s[WIDTH-1:0];
    else
      fin_res = prod_s[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = special ? S_DONE : S_RUN;
      S_RUN:  if (cnt == LAST) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // result/tag_out are loaded on the edge entering S_DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      dvsr      <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= bus.op;
      sa    <= sa_in;
      sb    <= sb_in;
      hi    <= '0;
      lo    <= a_mag;
      dvsr  <= b_mag;
      tag_q <= bus.tag_in;
      if (special) begin
        result_q  <= spec_res;
        tag_out_q <= bus.tag_in;
      end
    end else if (state == S_RUN && !bus.flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        result_q  <= fin_res;
        tag_out_q <= tag_q;
      end
    end
  end

  assign bus.ready   = (state == S_IDLE);
  assign bus.busy    = (state != S_IDLE);
  assign bus.done    = (state == S_DONE);
  assign bus.result  = result_q;
  assign bus.tag_out = tag_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit and 8-bit instances, hand-computed vectors,
// special cases, flush/reset abandonment and start held high across busy periods.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] last32;
  logic [4:0]  last_tag32;

  muldiv_unit_if #(.WIDTH(32), .TAG_W(5)) m32 ();
  muldiv_unit_if #(.WIDTH(8),  .TAG_W(5)) m8 ();

  muldiv_unit #(.WIDTH(32), .TAG_W(5)) d32 (.clk(clk), .rst(rst), .bus(m32.slave));
  muldiv_unit #(.WIDTH(8),  .TAG_W(5)) d8  (.clk(clk), .rst(rst), .bus(m8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Issue one request, measure cycles until done (1 = the cycle right after accept).
  task automatic run_op(input bit w8, input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        input logic [31:0] exp, input int exp_cyc);
    int cyc;
    logic dn;
    logic [31:0] res;
    logic [4:0]  tg;
    @(negedge clk);
    if (w8) begin
      m8.start = 1'b1; m8.op = op; m8.a = a[7:0]; m8.b = b[7:0]; m8.tag_in = t;
    end else begin
      m32.start = 1'b1; m32.op = op; m32.a = a; m32.b = b; m32.tag_in = t;
    end
    @(posedge clk); #1;
    m8.start = 1'b0; m32.start = 1'b0;
    cyc = 1;
    dn  = w8 ? m8.done : m32.done;
    while (!dn && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      dn = w8 ? m8.done : m32.done;
    end
    res = w8 ? {24'b0, m8.result} : m32.result;
    tg  = w8 ? m8.tag_out : m32.tag_out;
    chk({name, "_lat"}, 32'(cyc), 32'(exp_cyc));
    chk(name, res, exp);
    chk({name, "_tag"}, {27'b0, tg}, {27'b0, t});
    if (!w8) begin
      last32     = exp;
      last_tag32 = t;
    end
    @(posedge clk); #1;
    chk({name, "_rdy"}, {30'b0, (w8 ? m8.ready : m32.ready), (w8 ? m8.done : m32.done)}, 32'h2);
  endtask

  initial begin
    int dn;
    int acc_n;
    int done_n;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;
    checks = 0; failures = 0; last32 = '0; last_tag32 = '0;
    rst = 1'b1;
    m32.start = 1'b0; m32.op = '0; m32.a = '0; m32.b = '0; m32.tag_in = '0; m32.flush = 1'b0;
    m8.start  = 1'b0; m8.op  = '0; m8.a  = '0; m8.b  = '0; m8.tag_in  = '0; m8.flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready32", {31'b0, m32.ready}, 32'd1);
    chk("rst_busy32",  {31'b0, m32.busy},  32'd0);
    chk("rst_done32",  {31'b0, m32.done},  32'd0);
    chk("rst_result32", m32.result, 32'd0);
    chk("rst_tag32",   {27'b0, m32.tag_out}, 32'd0);
    chk("rst_ready8",  {31'b0, m8.ready}, 32'd1);
    chk("rst_result8", {24'b0, m8.result}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // 32-bit vectors
    run_op(0, "mul_7_m3",      MUL,    32'd7,        32'hFFFFFFFD, 5'h13, 32'hFFFFFFEB, 33);
    run_op(0, "mulh_min_min",  MULH,   32'h80000000, 32'h80000000, 5'h01, 32'h40000000, 33);
    run_op(0, "mulhu_ones",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 33);
    run_op(0, "mulhsu_ones",   MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h03, 32'hFFFFFFFF, 33);
    run_op(0, "mulh_7_m3",     MULH,   32'd7,        32'hFFFFFFFD, 5'h04, 32'hFFFFFFFF, 33);
    run_op(0, "div_m7_2",      DIV,    32'hFFFFFFF9, 32'd2,        5'h05, 32'hFFFFFFFD, 33);
    run_op(0, "rem_m7_2",      REM,    32'hFFFFFFF9, 32'd2,        5'h06, 32'hFFFFFFFF, 33);
    run_op(0, "divu_100_7",    DIVU,   32'd100,      32'd7,        5'h07, 32'd14,       33);
    run_op(0, "remu_100_7",    REMU,   32'd100,      32'd7,        5'h08, 32'd2,        33);
    run_op(0, "div_5_0",       DIV,    32'd5,        32'd0,        5'h09, 32'hFFFFFFFF, 1);
    run_op(0, "rem_5_0",       REM,    32'd5,        32'd0,        5'h0A, 32'd5,        1);
    run_op(0, "divu_5_0",      DIVU,   32'd5,        32'd0,        5'h0B, 32'hFFFFFFFF, 1);
    run_op(0, "remu_5_0",      REMU,   32'd5,        32'd0,        5'h0C, 32'd5,        1);
    run_op(0, "div_ovf",       DIV,    32'h80000000, 32'hFFFFFFFF, 5'h0D, 32'h80000000, 1);
    run_op(0, "rem_ovf",       REM,    32'h80000000, 32'hFFFFFFFF, 5'h0E, 32'd0,        1);
    run_op(0, "divu_min_ones", DIVU,   32'h80000000, 32'hFFFFFFFF, 5'h1F, 32'd0,        33);

    // 8-bit vectors (same cases truncated)
    run_op(1, "w8_mul_7_m3",   MUL,   32'h07, 32'hFD, 5'h11, 32'hEB, 9);
    run_op(1, "w8_mulh_min",   MULH,  32'h80, 32'h80, 5'h12, 32'h40, 9);
    run_op(1, "w8_mulhu_ones", MULHU, 32'hFF, 32'hFF, 5'h13, 32'hFE, 9);
    run_op(1, "w8_div_m7_2",   DIV,   32'hF9, 32'h02, 5'h14, 32'hFD, 9);
    run_op(1, "w8_rem_m7_2",   REM,   32'hF9, 32'h02, 5'h15, 32'hFF, 9);
    run_op(1, "w8_divu_100_7", DIVU,  32'h64, 32'h07, 5'h16, 32'h0E, 9);
    run_op(1, "w8_remu_100_7", REMU,  32'h64, 32'h07, 5'h17, 32'h02, 9);
    run_op(1, "w8_div_5_0",    DIV,   32'h05, 32'h00, 5'h18, 32'hFF, 1);
    run_op(1, "w8_div_ovf",    DIV,   32'h80, 32'hFF, 5'h19, 32'h80, 1);
    run_op(1, "w8_rem_ovf",    REM,   32'h80, 32'hFF, 5'h1A, 32'h00, 1);

    // Flush partway through S_RUN
    @(negedge clk);
    m32.start = 1'b1; m32.op = MUL; m32.a = 32'd3; m32.b = 32'd5; m32.tag_in = 5'h1C;
    @(posedge clk); #1;
    m32.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) m32.flush = 1'b1;
    @(posedge clk); #1;
    m32.flush = 1'b0;
    chk("flush_done",   {31'b0, m32.done},  32'd0);
    chk("flush_ready",  {31'b0, m32.ready}, 32'd1);
    chk("flush_result", m32.result, last32);
    chk("flush_tag",    {27'b0, m32.tag_out}, {27'b0, last_tag32});
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (m32.done) dn++; end
    chk("flush_no_done", 32'(dn), 32'd0);

    // start coincident with flush is dropped
    @(negedge clk);
    m32.start = 1'b1; m32.flush = 1'b1; m32.op = DIVU; m32.a = 32'd9; m32.b = 32'd3;
    m32.tag_in = 5'h1D;
    @(posedge clk); #1;
    m32.start = 1'b0; m32.flush = 1'b0;
    chk("sf_ready", {31'b0, m32.ready}, 32'd1);
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (m32.done) dn++; end
    chk("sf_no_done", 32'(dn), 32'd0);
    chk("sf_result", m32.result, last32);

    // Reset mid-run
    @(negedge clk);
    m32.start = 1'b1; m32.op = MUL; m32.a = 32'd11; m32.b = 32'd13; m32.tag_in = 5'h1E;
    @(posedge clk); #1;
    m32.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_state", {28'b0, m32.ready, m32.busy, m32.done, 1'b0}, 32'h8);
    chk("mrst_result", m32.result, 32'd0);
    chk("mrst_tag", {27'b0, m32.tag_out}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(0, "post_rst_mul", MUL, 32'd6, 32'd7, 5'h03, 32'd42, 33);

    // start held high with changing operands on the 8-bit unit
    acc_n = 0; done_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      m8.start = 1'b1; m8.op = DIVU; m8.tag_in = 5'h05;
      m8.a = 8'(i * 13 + 5);
      m8.b = 8'(i % 5 + 1);
      if (m8.ready) begin
        qa.push_back(m8.a);
        qb.push_back(m8.b);
        acc_n++;
      end
      @(posedge clk); #1;
      if (m8.done) begin
        done_n++;
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          chk("held_divu", {24'b0, m8.result}, {24'b0, ea / eb});
        end
      end
    end
    @(negedge clk) m8.start = 1'b0;
    chk("held_accepts", 32'(acc_n), 32'd3);
    chk("held_dones",   32'(done_n), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
